// File: rtl/bus_slave_fabric_pkg.sv
// Shared types and default constants for the bus slave fabric.
//   fabric_state_t    : handshake FSM states
//   FABRIC_TIMEOUT    : default slave-ack timeout in clock cycles
//   FABRIC_ERROR_WORD : default read data returned on a failed transaction
//   ERR_COUNT_W       : width of the saturating error counter
package bus_slave_fabric_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT_ACK,
    ACK,
    REL_SLAVE,
    ERR_ACK
  } fabric_state_t;

  localparam int unsigned FABRIC_TIMEOUT    = 1023;
  localparam logic [31:0] FABRIC_ERROR_WORD = 32'hDEADBEEF;
  localparam int unsigned ERR_COUNT_W       = 16;

endpackage

// File: rtl/bus_slave_fabric_slave_rdata_mux.sv
// Registered N:1 read-data mux for the bus slave fabric.
//   clk_i     : system clock
//   rst_ni    : synchronous active-low reset (clears the output register)
//   capture_i : load the slice of rdata_i selected by slot_i
//   error_i   : load ERROR_WORD (takes priority over capture_i)
//   slot_i    : slave slot index
//   rdata_i   : concatenated slave read data, slave k at [k*DATA_W +: DATA_W]
//   rdata_o   : registered read data
module slave_rdata_mux #(
  parameter int unsigned       NUM_SLAVES = 8,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       SLOT_BITS  = 4,
  parameter logic [DATA_W-1:0] ERROR_WORD = '1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         capture_i,
  input  logic                         error_i,
  input  logic [SLOT_BITS-1:0]         slot_i,
  input  logic [NUM_SLAVES*DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0]            rdata_o
);

  logic [DATA_W-1:0] slice_d;
  logic [DATA_W-1:0] rdata_q;

  // Compare-based select keeps out-of-range slots at zero instead of
  // indexing past the end of rdata_i.
  always_comb begin
    slice_d = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (32'(slot_i) == k) slice_d = rdata_i[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (error_i) begin
      rdata_q <= ERROR_WORD;
    end else if (capture_i) begin
      rdata_q <= slice_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_slave_fabric.sv
// Fabric between the internal-bus master and NUM_SLAVES slave channels.
// Decodes the slot from the address MSBs, drives a one-hot slave select,
// waits (bounded) for the slave acknowledge and returns a registered read
// word. Missing/unmapped/silent slaves produce an error acknowledge with
// ERROR_WORD so the master link never hangs.
//   clk, reset                   : clock, synchronous active-low reset
//   m_handshake_1, m_RW, m_addr, m_wdata : master request side
//   m_handshake_2, m_rdata, m_error      : master response side
//   s_sel                        : one-hot slave select (slave handshake_1)
//   s_RW, s_addr, s_wdata        : registered broadcast to all slaves
//   s_handshake_2, s_rdata       : per-slave acknowledge and read data
//   err_count                    : saturating count of failed transactions
module bus_slave_fabric
  import bus_slave_fabric_pkg::*;
#(
  parameter int unsigned       NUM_SLAVES = 8,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       SLOT_BITS  = 4,
  parameter int unsigned       TIMEOUT    = FABRIC_TIMEOUT,
  parameter logic [DATA_W-1:0] ERROR_WORD = DATA_W'(FABRIC_ERROR_WORD)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_handshake_1,
  input  logic                         m_RW,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  output logic                         m_handshake_2,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_error,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic                         s_RW,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES-1:0]        s_handshake_2,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  output logic [ERR_COUNT_W-1:0]       err_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  fabric_state_t          state_q;
  logic                   m_handshake_2_q;
  logic                   m_error_q;
  logic [NUM_SLAVES-1:0]  s_sel_q;
  logic [NUM_SLAVES-1:0]  slave_mask_q;
  logic                   s_RW_q;
  logic [ADDR_W-1:0]      s_addr_q;
  logic [DATA_W-1:0]      s_wdata_q;
  logic [TW-1:0]          timer_q;
  logic [ERR_COUNT_W-1:0] err_count_q;

  logic [SLOT_BITS-1:0]   slot;
  logic                   slot_valid;
  logic [NUM_SLAVES-1:0]  slot_onehot;
  logic                   ack;
  logic                   any_ack;
  logic                   timed_out;
  logic                   capture;
  logic                   load_err;
  logic [ERR_COUNT_W-1:0] err_count_inc;

  assign slot       = s_addr_q[ADDR_W-1 -: SLOT_BITS];
  assign slot_valid = 32'(slot) < NUM_SLAVES;

  always_comb begin
    slot_onehot = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      slot_onehot[k] = (32'(slot) == k);
    end
  end

  // slave_mask_q survives the s_sel drop so REL_SLAVE can still watch the
  // selected slave's acknowledge fall.
  assign ack       = |(s_handshake_2 & slave_mask_q);
  assign any_ack   = |s_handshake_2;
  assign timed_out = (timer_q == TW'(TIMEOUT - 1));
  assign capture   = (state_q == WAIT_ACK) && ack && s_RW_q;
  assign load_err  = ((state_q == DECODE) && !slot_valid) ||
                     ((state_q == WAIT_ACK) && !ack && timed_out);
  assign err_count_inc = (err_count_q == '1) ? err_count_q
                                             : err_count_q + ERR_COUNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      m_handshake_2_q <= 1'b0;
      m_error_q       <= 1'b0;
      s_sel_q         <= '0;
      slave_mask_q    <= '0;
      s_RW_q          <= 1'b0;
      s_addr_q        <= '0;
      s_wdata_q       <= '0;
      timer_q         <= '0;
      err_count_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A stale ack (e.g. after a timeout) blocks new requests until it drops.
          if (m_handshake_1 && !any_ack) begin
            s_RW_q    <= m_RW;
            s_addr_q  <= m_addr;
            s_wdata_q <= m_wdata;
            state_q   <= DECODE;
          end
        end
        DECODE: begin
          if (slot_valid) begin
            s_sel_q      <= slot_onehot;
            slave_mask_q <= slot_onehot;
            timer_q      <= '0;
            state_q      <= WAIT_ACK;
          end else begin
            m_handshake_2_q <= 1'b1;
            m_error_q       <= 1'b1;
            err_count_q     <= err_count_inc;
            state_q         <= ERR_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack) begin
            m_handshake_2_q <= 1'b1;
            m_error_q       <= 1'b0;
            state_q         <= ACK;
          end else if (timed_out) begin
            s_sel_q         <= '0;
            slave_mask_q    <= '0;
            m_handshake_2_q <= 1'b1;
            m_error_q       <= 1'b1;
            err_count_q     <= err_count_inc;
            state_q         <= ERR_ACK;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ACK: begin
          if (!m_handshake_1) begin
            s_sel_q <= '0;
            state_q <= REL_SLAVE;
          end
        end
        REL_SLAVE: begin
          if (!ack) begin
            m_handshake_2_q <= 1'b0;
            slave_mask_q    <= '0;
            state_q         <= IDLE;
          end
        end
        ERR_ACK: begin
          if (!m_handshake_1) begin
            m_handshake_2_q <= 1'b0;
            m_error_q       <= 1'b0;
            state_q         <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  slave_rdata_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .DATA_W     (DATA_W),
    .SLOT_BITS  (SLOT_BITS),
    .ERROR_WORD (ERROR_WORD)
  ) u_rdata_mux (
    .clk_i     (clk),
    .rst_ni    (reset),
    .capture_i (capture),
    .error_i   (load_err),
    .slot_i    (slot),
    .rdata_i   (s_rdata),
    .rdata_o   (m_rdata)
  );

  assign m_handshake_2 = m_handshake_2_q;
  assign m_error       = m_error_q;
  assign s_sel         = s_sel_q;
  assign s_RW          = s_RW_q;
  assign s_addr        = s_addr_q;
  assign s_wdata       = s_wdata_q;
  assign err_count     = err_count_q;

endmodule
